// File: rtl/pwm_timing_ctrl_pkg.sv
// Shared carrier constants and types for the PWM timing path.
// Imported by pwm_timing_ctrl, its counter and the downstream pwm_generator.
package pwm_timing_ctrl_pkg;
  localparam int CNT_CYCLE = 512;
  localparam int TIME_W    = $clog2(CNT_CYCLE);
  localparam int DW        = 8;

  typedef logic [TIME_W-1:0] time_t;
  typedef logic [DW-1:0]     duty_t;
  typedef logic [DW-1:0]     phase_t;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    RUN       = 1'b1
  } state_t;

  localparam time_t TIME_LAST = time_t'(CNT_CYCLE - 1);
endpackage

// File: rtl/pwm_timing_ctrl_time_cnt_gen.sv
// Carrier time counter with SYNC realign; flags the carrier boundary combinationally.
// TIME resets to 0 the cycle after SYNC or after TIME_LAST; held at 0 while not running.
module pwm_timing_ctrl_time_cnt_gen
  import pwm_timing_ctrl_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_run,
  input  logic  i_sync,
  output time_t o_time,
  output logic  o_boundary
);

  time_t r_time;
  logic  w_last;

  // Explicit compare keeps the wrap correct if CNT_CYCLE is not 2**TIME_W.
  assign w_last     = (r_time == TIME_LAST);
  assign o_boundary = (i_run & w_last) | i_sync;
  assign o_time     = r_time;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_time <= '0;
    end else if (i_sync || !i_run || w_last) begin
      r_time <= '0;
    end else begin
      r_time <= r_time + time_t'(1);
    end
  end

endmodule

// File: rtl/pwm_timing_ctrl.sv
// Double-buffers duty/phase and applies them only at carrier boundaries; output silent until first SYNC.
// New values visible in the TIME==0 cycle with UPDATE; IN_READY low while a word waits in the shadow.
module pwm_timing_ctrl
  import pwm_timing_ctrl_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              SYNC,
  input  logic [DW-1:0]     DUTY_IN,
  input  logic [DW-1:0]     PHASE_IN,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [TIME_W-1:0] TIME,
  output logic [DW-1:0]     DUTY,
  output logic [DW-1:0]     PHASE,
  output logic              UPDATE
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_out_en;
  logic   w_run;
  logic   w_boundary;
  logic   w_accept;
  logic   w_apply;
  time_t  w_time;

  duty_t  r_shadow_duty;
  phase_t r_shadow_phase;
  logic   r_pending;
  duty_t  r_duty;
  phase_t r_phase;
  logic   r_update;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= WAIT_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_out_en    = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      WAIT_SYNC: begin
        if (SYNC) w_state_nxt = RUN;
      end
      RUN: begin
        w_out_en = 1'b1;
        w_run    = 1'b1;
      end
      default: w_state_nxt = WAIT_SYNC;
    endcase
  end

  pwm_timing_ctrl_time_cnt_gen u_time_cnt (
    .i_clk      (CLK),
    .i_rst_n    (RST_N),
    .i_run      (w_run),
    .i_sync     (SYNC),
    .o_time     (w_time),
    .o_boundary (w_boundary)
  );

  // Accept only into an empty shadow, so a word accepted on a boundary waits for the next one.
  assign w_accept = IN_VALID & ~r_pending;
  assign w_apply  = w_boundary & r_pending;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_shadow_duty  <= '0;
      r_shadow_phase <= '0;
      r_pending      <= 1'b0;
      r_duty         <= '0;
      r_phase        <= '0;
      r_update       <= 1'b0;
    end else begin
      r_update <= w_apply;
      if (w_accept) begin
        r_shadow_duty  <= DUTY_IN;
        r_shadow_phase <= PHASE_IN;
        r_pending      <= 1'b1;
      end else if (w_apply) begin
        r_duty    <= r_shadow_duty;
        r_phase   <= r_shadow_phase;
        r_pending <= 1'b0;
      end
    end
  end

  assign IN_READY = ~r_pending;
  assign TIME     = w_time;
  assign DUTY     = w_out_en ? r_duty  : '0;
  assign PHASE    = w_out_en ? r_phase : '0;
  assign UPDATE   = r_update;

endmodule

// File: tb/tb_pwm_timing_ctrl.sv
// Directed bench for pwm_timing_ctrl: expected applications queued at accept, checked on each UPDATE.
module tb_pwm_timing_ctrl;
  import pwm_timing_ctrl_pkg::*;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              SYNC;
  logic [DW-1:0]     DUTY_IN;
  logic [DW-1:0]     PHASE_IN;
  logic              IN_VALID;
  logic              IN_READY;
  logic [TIME_W-1:0] TIME;
  logic [DW-1:0]     DUTY;
  logic [DW-1:0]     PHASE;
  logic              UPDATE;

  typedef struct {
    int duty;
    int phase;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  pwm_timing_ctrl dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .SYNC     (SYNC),
    .DUTY_IN  (DUTY_IN),
    .PHASE_IN (PHASE_IN),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .TIME     (TIME),
    .DUTY     (DUTY),
    .PHASE    (PHASE),
    .UPDATE   (UPDATE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every UPDATE pulse must match the oldest queued application.
  always @(negedge CLK) begin
    if (UPDATE === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_update: UPDATE=1 at TIME=%0d DUTY=%0d PHASE=%0d, expected no update",
                 TIME, DUTY, PHASE);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("upd_duty",  int'(DUTY),  e.duty);
        check("upd_phase", int'(PHASE), e.phase);
        check("upd_time",  int'(TIME),  0);
      end
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic wait_time(input int t);
    for (int i = 0; i < 1100; i++) begin
      if (int'(TIME) == t) return;
      step();
    end
    check("wait_time_timeout", int'(TIME), t);
  endtask

  task automatic push(input int d, input int p);
    exp_t e;
    e.duty  = d;
    e.phase = p;
    sb.push_back(e);
  endtask

  // Present one word for a single cycle; caller guarantees IN_READY is high.
  task automatic write1(input int d, input int p);
    DUTY_IN  = DW'(d);
    PHASE_IN = DW'(p);
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
  endtask

  initial begin
    RST_N    = 1'b0;
    SYNC     = 1'b0;
    DUTY_IN  = '0;
    PHASE_IN = '0;
    IN_VALID = 1'b0;
    repeat (3) step();
    check("rst_time",  int'(TIME),     0);
    check("rst_duty",  int'(DUTY),     0);
    check("rst_phase", int'(PHASE),    0);
    check("rst_upd",   int'(UPDATE),   0);
    check("rst_ready", int'(IN_READY), 1);
    RST_N = 1'b1;
    step();

    // Word before SYNC: held in shadow, output stays silent.
    write1(255, 50);
    push(255, 50);
    check("pre_sync_ready", int'(IN_READY), 0);
    repeat (20) step();
    check("pre_sync_time",  int'(TIME),  0);
    check("pre_sync_duty",  int'(DUTY),  0);
    check("pre_sync_phase", int'(PHASE), 0);

    // First SYNC applies the pending word in the TIME==0 cycle.
    SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    check("sync_time",  int'(TIME),     0);
    check("sync_ready", int'(IN_READY), 1);
    check("sync_duty",  int'(DUTY),     255);
    step();
    check("run_time1", int'(TIME), 1);
    wait_time(511);
    step();
    check("wrap_time", int'(TIME), 0);
    check("wrap_duty", int'(DUTY), 255);

    // Write at TIME=100, then hold a second word that must stall.
    wait_time(100);
    DUTY_IN  = 8'd240;
    PHASE_IN = 8'd60;
    IN_VALID = 1'b1;
    step();
    push(240, 60);
    DUTY_IN  = 8'd250;
    PHASE_IN = 8'd200;
    check("stall_ready", int'(IN_READY), 0);
    wait_time(511);
    check("stall_ready_511", int'(IN_READY), 0);
    check("hold_duty_511",   int'(DUTY),     255);
    check("hold_phase_511",  int'(PHASE),    50);
    step();
    check("freed_ready", int'(IN_READY), 1);
    push(250, 200);
    step();
    IN_VALID = 1'b0;
    check("second_accepted", int'(IN_READY), 0);
    check("second_time",     int'(TIME),     1);
    check("active_240",      int'(DUTY),     240);
    wait_time(511);
    check("still_240", int'(DUTY), 240);
    step();
    check("now_250", int'(DUTY), 250);

    // SYNC mid-cycle with a pending word.
    wait_time(5);
    write1(0, 255);
    push(0, 255);
    wait_time(300);
    SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    check("sync300_time",  int'(TIME),  0);
    check("sync300_phase", int'(PHASE), 255);
    step();
    check("sync300_next", int'(TIME), 1);

    // SYNC coinciding with TIME=511: one boundary, one UPDATE.
    wait_time(5);
    write1(17, 34);
    push(17, 34);
    wait_time(511);
    SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    check("sync511_time", int'(TIME), 0);
    step();
    check("sync511_single", int'(UPDATE), 0);
    check("sync511_next",   int'(TIME),   1);

    // Back-to-back SYNC: both realign, only the first has data.
    wait_time(50);
    write1(9, 9);
    push(9, 9);
    SYNC = 1'b1;
    step();
    check("b2b_time_a", int'(TIME), 0);
    step();
    SYNC = 1'b0;
    check("b2b_time_b", int'(TIME),   0);
    check("b2b_upd_b",  int'(UPDATE), 0);
    step();
    check("b2b_time_c", int'(TIME), 1);

    // Accept coinciding with the wrap goes to shadow only.
    wait_time(511);
    write1(77, 88);
    push(77, 88);
    check("acc_bnd_upd",   int'(UPDATE),   0);
    check("acc_bnd_time",  int'(TIME),     0);
    check("acc_bnd_duty",  int'(DUTY),     9);
    check("acc_bnd_ready", int'(IN_READY), 0);
    wait_time(511);
    step();
    check("acc_bnd_applied", int'(DUTY), 77);

    // Async reset mid-cycle drops the pending word.
    wait_time(100);
    write1(123, 45);
    wait_time(200);
    check("prerst_ready", int'(IN_READY), 0);
    #2 RST_N = 1'b0;
    #1;
    check("arst_time",  int'(TIME),     0);
    check("arst_duty",  int'(DUTY),     0);
    check("arst_phase", int'(PHASE),    0);
    check("arst_upd",   int'(UPDATE),   0);
    check("arst_ready", int'(IN_READY), 1);
    step();
    RST_N = 1'b1;
    repeat (600) step();
    check("postrst_time", int'(TIME), 0);
    SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    check("postrst_sync_duty", int'(DUTY),   0);
    check("postrst_sync_upd",  int'(UPDATE), 0);
    step();
    check("postrst_run", int'(TIME), 1);

    repeat (3) step();
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
